fmps_test_packet_gen: RTL and testbench
=======================================

Name: fmps_test_packet_gen

Overview:
Parametrised successor of the single-packet FMPS test-link writer. Generates multi-word dummy FMPS packets for link bring-up and soak tests on the Aurora TX AXI-Stream.
- Configurable payload length, packets per session, starting FMPS index and data pattern.
- Handles backpressure, session abort and link drop.
- Lives entirely in the Aurora user clock domain; any CDC of configuration is done by the instantiating wrapper.

Parameters:
DATA_WIDTH, 32, stream word width (≥32); bits above 31 are zero.
MAX_PAYLOAD_WORDS, 8, largest payload per packet (1..1023).
MAX_FMPSS, 32, index space; FMPS index wraps modulo MAX_FMPSS.
FIFO_AW, 3, output FIFO address width (depth 2**FIFO_AW).
HEADER_MAGIC, 16'hB6CF, header bits [31:16].
DATA_MAGIC, 16'hCACA, payload bits [23:8] in counter mode.

Ports:
auroraUserClk  in  1  sole clock
auroraUserRstN  in  1  synchronous active-low reset
cfgPayloadWords  in  $clog2(MAX_PAYLOAD_WORDS+1)  payload words per packet; 0 treated as 1
cfgPacketCount  in  6  packets per session; 0 = empty session
cfgFirstIndex  in  $clog2(MAX_FMPSS)  index of first packet
cfgPatternMode  in  2  0 counter, 1 walking-one, 2 all-ones, 3 = counter
faStrobe  in  1  start/restart session
channelUp  in  1  Aurora channel up
txTdata  out  DATA_WIDTH  AXIS data
txTvalid  out  1  AXIS valid
txTlast  out  1  AXIS last (final word of each packet)
txTready  in  1  AXIS ready
busy  out  1  session in progress or FIFO non-empty
sessionCount  out  8  sessions started, wraps 255→0
abortStrobe  out  1  one-cycle pulse on session abort

Behaviour:
- Reset (auroraUserRstN low at a clock edge) has priority over everything:
  - State goes to IDLE and the FIFO is cleared.
  - txTvalid=0, txTlast=0, txTdata=0, busy=0, sessionCount=0, abortStrobe=0.
- Configuration inputs are sampled only on faStrobe and held for the whole session.
- States:
  - IDLE: waits for faStrobe.
  - FLUSH: force-reads the FIFO until empty; txTvalid is held 0 while flushing. Exits to HEADER once the FIFO is empty and channelUp=1.
  - HEADER: writes the header word when FIFO count ≤ depth−3. Header = {HEADER_MAGIC, 1'b1, zero pad, index, 10-bit payload length}.
  - PAYLOAD: writes word k (k=0..N−1) under the same FIFO threshold. Word N−1 carries tlast=1. After the last word: if packets remain, index is incremented modulo MAX_FMPSS and the state returns to HEADER; otherwise IDLE.
- faStrobe in any state (including mid-packet):
  - sessionCount increments, config is latched, state goes to FLUSH.
  - abortStrobe pulses if the previous state was not IDLE.
  - Downstream may therefore see a truncated packet; this is accepted.
- channelUp falling in HEADER or PAYLOAD: abortStrobe pulses and the state goes to FLUSH. The next faStrobe restarts the session.
- cfgPacketCount=0: FLUSH then IDLE; no words are emitted.
- Payload patterns, word k:
  - Counter: {3'b0, index zero-extended to 5 bits, DATA_MAGIC, (sessionCount+k)[7:0]}.
  - Walking-one: 1<<(k mod 32).
  - All-ones: 32'hFFFFFFFF.
- FIFO is first-word-fall-through. txTvalid = !empty && !flushing. A word is popped on txTvalid && txTready.
- Latency: with the FIFO empty and channelUp=1, the header appears on txTvalid in the 4th cycle after faStrobe.
- Throughput: one word per cycle sustained when txTready=1.
- Stalls: txTdata and txTlast stay stable while txTvalid=1 and txTready=0.

Optional Feature:
FMPS_TEST_CHECKSUM_EN
- Defined: each packet gets one trailer word after the payload, equal to the XOR of the header and all payload words. tlast moves to the trailer, and the header length field still counts payload words only.
- Undefined: no trailer; tlast is on the last payload word.

Decomposition:
- Package fmps_test_pkg holds:
  - the state enum (IDLE, FLUSH, HEADER, PAYLOAD, plus TRAILER under the macro);
  - pattern-mode constants;
  - header field offsets;
  - the FIFO threshold constant.
- Sub-module fmps_test_word_gen: registered pattern generator. Inputs are mode, index, k and sessionCount; output is the next payload word.
- The output FIFO is the existing FWFT genericFifo.

Test Plan:
- Payload=3, packets=2, firstIndex=5, counter mode, ready=1 → 8 words. Headers 32'hB6CF_8000|(5<<10)|3 and |(6<<10)|3. Payload low bytes 1,2,3 (sessionCount=1). tlast on words 4 and 8.
- Same stimulus with txTready toggling 1010… → identical word sequence, data stable during stalls, no word lost or duplicated.
- firstIndex=31, packets=3 → header indexes 31, 0, 1.
- faStrobe during the second payload word → abortStrobe pulse, FIFO flushed, new session starts with sessionCount=2 and a fresh header.
- channelUp dropped mid-payload → abortStrobe, txTvalid=0 within 1 cycle, state IDLE after flush, busy=0.
- With FMPS_TEST_CHECKSUM_EN, payload=2, all-ones mode → trailer = header XOR 0 = header value, tlast only on the trailer.

Source files
------------

// File: rtl/fmps_test_pkg.sv
// fmps_test_pkg: shared types and constants for the FMPS test packet generator.
// The TRAILER state exists only when FMPS_TEST_CHECKSUM_EN is defined.
package fmps_test_pkg;
`ifdef FMPS_TEST_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FLUSH, HEADER, PAYLOAD, TRAILER} stateT;
`else
  typedef enum logic [1:0] {IDLE, FLUSH, HEADER, PAYLOAD} stateT;
`endif
  localparam logic [1:0] PAT_COUNTER = 2'd0;
  localparam logic [1:0] PAT_WALK = 2'd1;
  localparam logic [1:0] PAT_ONES = 2'd2;
  localparam logic [1:0] PAT_COUNTER_ALT = 2'd3;
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_VALID_BIT = 15;
  localparam int HDR_INDEX_LSB = 10;
  localparam int HDR_LEN_LSB = 0;
  localparam int FIFO_HEADROOM = 3;
  function automatic logic [31:0] makeHeader(logic [15:0] magic, logic [4:0] index, logic [9:0] len);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 16] = magic;
    h[HDR_VALID_BIT] = 1'b1;
    h[HDR_INDEX_LSB +: 5] = index;
    h[HDR_LEN_LSB +: 10] = len;
    return h;
  endfunction
endpackage

// File: rtl/fmps_test_word_gen.sv
// fmps_test_word_gen: registered payload pattern generator; word for (mode, index, k) appears one cycle later.
module fmps_test_word_gen
  import fmps_test_pkg::*;
#(
  parameter logic [15:0] DATA_MAGIC = 16'hCACA,
  parameter int IDX_W = 5
) (
  input logic auroraUserClk,
  input logic [1:0] mode,
  input logic [IDX_W-1:0] index,
  input logic [7:0] k,
  input logic [7:0] sessionCount,
  output logic [31:0] word
);
  logic [4:0] idx5;
  logic [7:0] cnt;
  assign idx5 = 5'(index);
  assign cnt = sessionCount + k;
  always_ff @(posedge auroraUserClk)
    word <= mode == PAT_WALK ? 32'd1 << k[4:0] : mode == PAT_ONES ? 32'hFFFF_FFFF : {3'b000, idx5, DATA_MAGIC, cnt};
endmodule

// File: rtl/genericFifo.sv
// genericFifo: first-word-fall-through synchronous FIFO of depth 2**AW with occupancy count.
module genericFifo #(
  parameter int WIDTH = 8,
  parameter int AW = 3
) (
  input logic clk,
  input logic rstN,
  input logic wrEn,
  input logic [WIDTH-1:0] wrData,
  input logic rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic empty,
  output logic [AW:0] count
);
  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0] wrPtr, rdPtr;
  logic doWr, doRd;
  assign empty = count == '0;
  assign doWr = wrEn && count != (AW+1)'(2**AW);
  assign doRd = rdEn && !empty;
  assign rdData = mem[rdPtr];
  always_ff @(posedge clk) if (doWr) mem[wrPtr] <= wrData;
  always_ff @(posedge clk) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + AW'(1);
      if (doRd) rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(doWr) - (AW+1)'(doRd);
    end
  end
endmodule

// File: rtl/fmps_test_packet_gen.sv
// fmps_test_packet_gen: multi-word dummy FMPS packet generator for Aurora TX bring-up and soak tests.
// Define FMPS_TEST_CHECKSUM_EN to append an XOR trailer word to every packet.
module fmps_test_packet_gen
  import fmps_test_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_PAYLOAD_WORDS = 8,
  parameter int MAX_FMPSS = 32,
  parameter int FIFO_AW = 3,
  parameter logic [15:0] HEADER_MAGIC = 16'hB6CF,
  parameter logic [15:0] DATA_MAGIC = 16'hCACA,
  localparam int LEN_W = $clog2(MAX_PAYLOAD_WORDS + 1),
  localparam int IDX_W = $clog2(MAX_FMPSS)
) (
  input logic auroraUserClk,
  input logic auroraUserRstN,
  input logic [LEN_W-1:0] cfgPayloadWords,
  input logic [5:0] cfgPacketCount,
  input logic [IDX_W-1:0] cfgFirstIndex,
  input logic [1:0] cfgPatternMode,
  input logic faStrobe,
  input logic channelUp,
  output logic [DATA_WIDTH-1:0] txTdata,
  output logic txTvalid,
  output logic txTlast,
  input logic txTready,
  output logic busy,
  output logic [7:0] sessionCount,
  output logic abortStrobe
);
  stateT state, stateNext;
  logic [IDX_W-1:0] idx;
  logic [9:0] k, nWords;
  logic [5:0] pktLeft;
  logic [1:0] mode;
  logic dropped, emit, emitSide, emitLast, abortNow, roomOk, sending;
  logic pendEn, pendSel, pendLast, fifoEmpty, fifoPop;
  logic [31:0] pendWord, genWord, wrWord, sideWord, headerWord;
  logic [FIFO_AW:0] fifoCount;
  logic [32:0] fifoOut;
  assign headerWord = makeHeader(HEADER_MAGIC, 5'(idx), nWords);
  assign wrWord = pendSel ? pendWord : genWord;
  assign roomOk = fifoCount <= (FIFO_AW+1)'(2**FIFO_AW - FIFO_HEADROOM);
  assign abortNow = faStrobe || (sending && !channelUp);
`ifdef FMPS_TEST_CHECKSUM_EN
  logic [31:0] acc;
  assign sending = state inside {HEADER, PAYLOAD, TRAILER};
  // The last payload word may still be in the write stage when the trailer is issued.
  assign sideWord = state == TRAILER ? acc ^ (pendEn ? wrWord : 32'd0) : headerWord;
  always_ff @(posedge auroraUserClk)
    if (!auroraUserRstN) acc <= '0;
    else if (pendEn) acc <= (pendSel && !pendLast) ? wrWord : acc ^ wrWord;
`else
  assign sending = state inside {HEADER, PAYLOAD};
  assign sideWord = headerWord;
`endif
  always_comb begin
    stateNext = state;
    emit = 1'b0;
    emitSide = 1'b0;
    emitLast = 1'b0;
    if (abortNow) stateNext = FLUSH;
    else case (state)
      FLUSH: if (fifoEmpty && (dropped || channelUp)) stateNext = (dropped || pktLeft == 6'd0) ? IDLE : HEADER;
      HEADER: if (roomOk) begin
        emit = 1'b1;
        emitSide = 1'b1;
        stateNext = PAYLOAD;
      end
      PAYLOAD: if (roomOk) begin
        emit = 1'b1;
`ifdef FMPS_TEST_CHECKSUM_EN
        if (k == nWords - 10'd1) stateNext = TRAILER;
      end
      TRAILER: if (roomOk) begin
        emit = 1'b1;
        emitSide = 1'b1;
        emitLast = 1'b1;
        stateNext = pktLeft == 6'd1 ? IDLE : HEADER;
      end
`else
        emitLast = k == nWords - 10'd1;
        if (emitLast) stateNext = pktLeft == 6'd1 ? IDLE : HEADER;
      end
`endif
      default: ;
    endcase
  end
  always_ff @(posedge auroraUserClk) begin
    if (!auroraUserRstN) begin
      state <= IDLE;
      idx <= '0;
      k <= '0;
      nWords <= 10'd1;
      pktLeft <= '0;
      mode <= '0;
      dropped <= 1'b0;
      sessionCount <= '0;
      abortStrobe <= 1'b0;
      pendEn <= 1'b0;
      pendSel <= 1'b0;
      pendLast <= 1'b0;
      pendWord <= '0;
    end else begin
      state <= stateNext;
      abortStrobe <= abortNow && state != IDLE;
      pendEn <= emit;
      pendSel <= emitSide;
      pendLast <= emitLast;
      if (emitSide) pendWord <= sideWord;
      if (faStrobe) begin
        sessionCount <= sessionCount + 8'd1;
        nWords <= cfgPayloadWords == '0 ? 10'd1 : 10'(cfgPayloadWords);
        pktLeft <= cfgPacketCount;
        idx <= cfgFirstIndex;
        mode <= cfgPatternMode;
        dropped <= 1'b0;
      end else begin
        if (abortNow) dropped <= 1'b1;
        if (emit) k <= state == HEADER ? 10'd0 : k + 10'd1;
        if (emit && emitLast) begin
          pktLeft <= pktLeft - 6'd1;
          idx <= idx == IDX_W'(MAX_FMPSS - 1) ? '0 : idx + IDX_W'(1);
        end
      end
    end
  end
  fmps_test_word_gen #(.DATA_MAGIC(DATA_MAGIC), .IDX_W(IDX_W)) wordGen (
    .auroraUserClk(auroraUserClk),
    .mode(mode),
    .index(idx),
    .k(k[7:0]),
    .sessionCount(sessionCount),
    .word(genWord)
  );
  genericFifo #(.WIDTH(33), .AW(FIFO_AW)) outFifo (
    .clk(auroraUserClk),
    .rstN(auroraUserRstN),
    .wrEn(pendEn),
    .wrData({pendLast, wrWord}),
    .rdEn(fifoPop),
    .rdData(fifoOut),
    .empty(fifoEmpty),
    .count(fifoCount)
  );
  assign txTvalid = !fifoEmpty && state != FLUSH;
  assign fifoPop = !fifoEmpty && (state == FLUSH || txTready);
  assign txTdata = txTvalid ? DATA_WIDTH'(fifoOut[31:0]) : '0;
  assign txTlast = txTvalid && fifoOut[32];
  assign busy = state != IDLE || !fifoEmpty || pendEn;
endmodule

// File: tb/tb_fmps_test_packet_gen.sv
// tb_fmps_test_packet_gen: randomized bench for fmps_test_packet_gen against a word-list reference model.
`timescale 1ns/1ps
module tb_fmps_test_packet_gen;
`ifdef FMPS_TEST_CHECKSUM_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif
  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [3:0] cfgPayloadWords = '0;
  logic [5:0] cfgPacketCount = '0;
  logic [4:0] cfgFirstIndex = '0;
  logic [1:0] cfgPatternMode = '0;
  logic faStrobe = 1'b0;
  logic channelUp = 1'b1;
  logic txTready = 1'b1;
  logic [31:0] txTdata;
  logic txTvalid, txTlast, busy, abortStrobe;
  logic [7:0] sessionCount;
  int nChecks = 0;
  int nBad = 0;
  int readyMode = 0;
  int sessions = 0;
  logic [32:0] expQ[$];
  logic [31:0] obsData[$];
  logic obsLast[$];
  logic [32:0] monExp;
  logic stallSeen = 1'b0;
  logic [31:0] stallData;
  logic stallLast;

  always #5 clk = ~clk;

  fmps_test_packet_gen dut (
    .auroraUserClk(clk),
    .auroraUserRstN(rstN),
    .cfgPayloadWords(cfgPayloadWords),
    .cfgPacketCount(cfgPacketCount),
    .cfgFirstIndex(cfgFirstIndex),
    .cfgPatternMode(cfgPatternMode),
    .faStrobe(faStrobe),
    .channelUp(channelUp),
    .txTdata(txTdata),
    .txTvalid(txTvalid),
    .txTlast(txTlast),
    .txTready(txTready),
    .busy(busy),
    .sessionCount(sessionCount),
    .abortStrobe(abortStrobe)
  );

  task automatic checkVal(string tag, logic [63:0] got, logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected word list for one session: header, payload words, optional XOR trailer.
  function automatic void pushSession(int pw, int pc, int fi, int pm, int sc);
    int n;
    n = pw == 0 ? 1 : pw;
    for (int p = 0; p < pc; p++) begin
      int idx;
      logic [31:0] h, cs, w;
      idx = (fi + p) % 32;
      h = 32'hB6CF8000 | 32'(idx << 10) | 32'(n);
      cs = h;
      expQ.push_back({1'b0, h});
      for (int j = 0; j < n; j++) begin
        if (pm == 1) w = 32'd1 << (j % 32);
        else if (pm == 2) w = 32'hFFFFFFFF;
        else w = 32'(idx << 24) | (32'hCACA << 8) | 32'((sc + j) % 256);
        cs ^= w;
        expQ.push_back({TRL == 0 && j == n - 1, w});
      end
      if (TRL != 0) expQ.push_back({1'b1, cs});
    end
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    txTready = readyMode == 0 ? 1'b1 : readyMode == 1 ? ~txTready : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) if (rstN) begin
    if (txTvalid && stallSeen) begin
      checkVal("stallData", txTdata, stallData);
      checkVal("stallLast", txTlast, stallLast);
    end
    stallSeen = txTvalid && !txTready;
    stallData = txTdata;
    stallLast = txTlast;
    if (txTvalid && txTready) begin
      checkVal("wordExpected", expQ.size() != 0, 1);
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        checkVal("data", txTdata, monExp[31:0]);
        checkVal("last", txTlast, monExp[32]);
      end
      obsData.push_back(txTdata);
      obsLast.push_back(txTlast);
    end
  end

  task automatic startSession(int pw, int pc, int fi, int pm, logic expAbort);
    cfgPayloadWords = 4'(pw);
    cfgPacketCount = 6'(pc);
    cfgFirstIndex = 5'(fi);
    cfgPatternMode = 2'(pm);
    faStrobe = 1'b1;
    @(posedge clk);
    #1;
    faStrobe = 1'b0;
    cfgPayloadWords = 4'($urandom_range(0, 8));
    cfgPacketCount = 6'($urandom_range(0, 63));
    cfgFirstIndex = 5'($urandom_range(0, 31));
    cfgPatternMode = 2'($urandom_range(0, 3));
    sessions++;
    expQ.delete();
    obsData.delete();
    obsLast.delete();
    pushSession(pw, pc, fi, pm, sessions % 256);
    checkVal("abortStrobe", abortStrobe, expAbort);
    checkVal("sessionCount", sessionCount, 64'(sessions % 256));
  endtask

  task automatic waitDone(string tag);
    int cyc;
    cyc = 0;
    while ((busy || expQ.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checkVal({tag, "_left"}, expQ.size(), 0);
    checkVal({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic waitWords(int n);
    int cyc;
    cyc = 0;
    while (obsData.size() < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkVal("reachWords", obsData.size() >= n, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, seen;
    repeat (3) @(posedge clk);
    #1;
    checkVal("rstValid", txTvalid, 0);
    checkVal("rstLast", txTlast, 0);
    checkVal("rstData", txTdata, 0);
    checkVal("rstBusy", busy, 0);
    checkVal("rstCount", sessionCount, 0);
    checkVal("rstAbort", abortStrobe, 0);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    readyMode = 0;
    startSession(3, 2, 5, 0, 1'b0);
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (txTvalid) break;
      lat++;
    end
    checkVal("latency", lat, 4);
    waitDone("basic");
    checkVal("basicWords", obsData.size(), 2 * (4 + TRL));
    checkVal("hdr0", obsData[0], 32'hB6CF9403);
    checkVal("hdr1", obsData[4 + TRL], 32'hB6CF9803);
    checkVal("pay0", obsData[1], 32'h05CACA01);
    checkVal("pay2", obsData[3], 32'h05CACA03);
    checkVal("hdr0Last", obsLast[0], 0);
    checkVal("end0Last", obsLast[3 + TRL], 1);
    checkVal("end1Last", obsLast[7 + 2 * TRL], 1);
    readyMode = 1;
    startSession(3, 2, 5, 0, 1'b0);
    waitDone("toggle");
    checkVal("toggleWords", obsData.size(), 2 * (4 + TRL));
    readyMode = 2;
    startSession(2, 3, 31, 0, 1'b0);
    waitDone("wrap");
    checkVal("wrapIdx0", (obsData[0] >> 10) & 31, 31);
    checkVal("wrapIdx1", (obsData[3 + TRL] >> 10) & 31, 0);
    checkVal("wrapIdx2", (obsData[6 + 2 * TRL] >> 10) & 31, 1);
    readyMode = 0;
    startSession(3, 2, 5, 0, 1'b0);
    waitWords(2);
    startSession(3, 2, 5, 0, 1'b1);
    checkVal("abortValid", txTvalid, 0);
    @(posedge clk);
    #1;
    checkVal("abortPulseEnd", abortStrobe, 0);
    waitDone("abort");
    checkVal("abortHdr", obsData[0], 32'hB6CF9403);
    checkVal("abortPay0", obsData[1], 64'(32'h05CACA00 | 32'(sessions % 256)));
    startSession(3, 2, 5, 0, 1'b0);
    waitWords(2);
    channelUp = 1'b0;
    @(posedge clk);
    #1;
    expQ.delete();
    checkVal("dropValid", txTvalid, 0);
    checkVal("dropAbort", abortStrobe, 1);
    waitDone("drop");
    seen = obsData.size();
    channelUp = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkVal("dropIdleBusy", busy, 0);
    checkVal("dropIdleWords", obsData.size(), seen);
    startSession(4, 0, 3, 1, 1'b0);
    waitDone("empty");
    checkVal("emptyWords", obsData.size(), 0);
    channelUp = 1'b0;
    startSession(2, 1, 7, 2, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    checkVal("linkWaitWords", obsData.size(), 0);
    checkVal("linkWaitBusy", busy, 1);
    channelUp = 1'b1;
    waitDone("linkWait");
`ifdef FMPS_TEST_CHECKSUM_EN
    startSession(2, 1, 9, 2, 1'b0);
    waitDone("cksum");
    checkVal("trailer", obsData[3], obsData[0]);
    checkVal("cksumPayLast", obsLast[2], 0);
    checkVal("cksumTrlLast", obsLast[3], 1);
`endif
    for (int i = 0; i < 16; i++) begin
      readyMode = int'($urandom_range(0, 2));
      startSession(int'($urandom_range(0, 8)), int'($urandom_range(0, 5)), int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 1'b0);
      waitDone("rand");
    end
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
